// File: rtl/pong_axi_regbank.sv
// pong_axi_regbank: AXI4-Lite slave exposing NUM_REGS RW / RO / W1C registers with byte strobes and SLVERR decode
// Ports: S_AXI_* AXI4-Lite slave (S_AXI_ACLK, asynchronous active-high S_AXI_ARESET);
//   reg_q stored RW/W1C values (RO slots 0); reg_wr_pulse one-cycle pulse per accepted RW/W1C write;
//   hw_status RO sources sampled on read; hw_event W1C set inputs sampled every cycle.
module pong_axi_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 16,
  parameter logic [2*NUM_REGS-1:0] REG_MODE = '0,
  parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     reg_q,
  output logic [NUM_REGS-1:0]                        reg_wr_pulse,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     hw_status,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]     hw_event
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int LSB = $clog2(DW / 8);
  localparam int IW = AW - LSB;
  function automatic logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] f_rst_q();
    f_rst_q = RESET_VAL;
    for (int i = 0; i < NUM_REGS; i++)
      if (REG_MODE[2*i +: 2] == 2'd1) f_rst_q[i*DW +: DW] = '0;
  endfunction
  localparam logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RST_Q = f_rst_q();
  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_wstate;
  r_state_t r_rstate;
  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0] r_bresp, r_rresp;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [DW/8-1:0] r_wstrb;
  logic [AW-1:0] r_waddr;
  logic [NUM_REGS*DW-1:0] r_q, w_q_nxt;
  logic [NUM_REGS-1:0] r_pulse, w_pulse_nxt, w_wsel;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_have_a, w_have_d, w_commit, w_wok, w_rok, w_unused;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata, w_bmask, w_rdata_nxt;
  logic [DW/8-1:0] w_wstrb;
  logic [IW-1:0] w_widx, w_ridx;
  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs = S_AXI_WVALID && r_wready;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;
  // a write completes on the edge where the second of AW/W arrives (or both together)
  assign w_have_a = w_aw_hs || r_wstate == W_HAVE_ADDR;
  assign w_have_d = w_w_hs || r_wstate == W_HAVE_DATA;
  assign w_commit = w_have_a && w_have_d;
  assign w_waddr = w_aw_hs ? S_AXI_AWADDR : r_waddr;
  assign w_wdata = w_w_hs ? S_AXI_WDATA : r_wdata;
  assign w_wstrb = w_w_hs ? S_AXI_WSTRB : r_wstrb;
  assign w_widx = w_waddr[AW-1:LSB];
  assign w_ridx = S_AXI_ARADDR[AW-1:LSB];
  assign w_wok = 32'(w_widx) < NUM_REGS;
  assign w_rok = 32'(w_ridx) < NUM_REGS;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, hw_status, hw_event};
  for (genvar b = 0; b < DW / 8; b++) begin : g_strb
    assign w_bmask[8*b +: 8] = {8{w_wstrb[b]}};
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
    assign w_wsel[i] = w_commit && 32'(w_widx) == i;
  end
  // W1C: the hw_event OR is applied after the clear so a simultaneous set wins
  always_comb begin
    w_q_nxt = r_q;
    w_pulse_nxt = '0;
    w_rdata_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (REG_MODE[2*i +: 2] == 2'd1)
        w_q_nxt[i*DW +: DW] = '0;
      else if (REG_MODE[2*i +: 2] == 2'd2)
        w_q_nxt[i*DW +: DW] = (r_q[i*DW +: DW] & ~(w_wsel[i] ? w_wdata & w_bmask : '0)) | hw_event[i*DW +: DW];
      else if (w_wsel[i])
        w_q_nxt[i*DW +: DW] = (r_q[i*DW +: DW] & ~w_bmask) | (w_wdata & w_bmask);
      w_pulse_nxt[i] = w_wsel[i] && REG_MODE[2*i +: 2] != 2'd1;
      if (32'(w_ridx) == i)
        w_rdata_nxt = REG_MODE[2*i +: 2] == 2'd1 ? hw_status[i*DW +: DW] : r_q[i*DW +: DW];
    end
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) r_q <= RST_Q;
    else r_q <= w_q_nxt;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      r_wstate <= W_IDLE;
      r_awready <= 1'b0;
      r_wready <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp <= 2'b00;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_pulse <= '0;
    end else begin
      if (w_aw_hs) r_waddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      r_pulse <= '0;
      if (r_wstate == W_RESP) begin
        if (S_AXI_BREADY) begin
          r_wstate <= W_IDLE;
          r_bvalid <= 1'b0;
          r_awready <= 1'b1;
          r_wready <= 1'b1;
        end
      end else if (w_commit) begin
        r_wstate <= W_RESP;
        r_awready <= 1'b0;
        r_wready <= 1'b0;
        r_bvalid <= 1'b1;
        r_bresp <= w_wok ? 2'b00 : 2'b10;
        r_pulse <= w_pulse_nxt;
      end else if (w_have_a) begin
        r_wstate <= W_HAVE_ADDR;
        r_awready <= 1'b0;
        r_wready <= 1'b1;
      end else if (w_have_d) begin
        r_wstate <= W_HAVE_DATA;
        r_awready <= 1'b1;
        r_wready <= 1'b0;
      end else begin
        r_awready <= 1'b1;
        r_wready <= 1'b1;
      end
    end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      r_rstate <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (r_rstate == R_DATA) begin
      if (S_AXI_RREADY) begin
        r_rstate <= R_IDLE;
        r_rvalid <= 1'b0;
        r_arready <= 1'b1;
      end
    end else if (w_ar_hs) begin
      r_rstate <= R_DATA;
      r_arready <= 1'b0;
      r_rvalid <= 1'b1;
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rok ? 2'b00 : 2'b10;
    end else r_arready <= 1'b1;
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY = r_wready;
  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = r_rresp;
  assign reg_q = r_q;
  assign reg_wr_pulse = r_pulse;
endmodule
